mmio_bus_fabric: RTL
====================

Name: mmio_bus_fabric

Overview:
- Parametrised memory-mapped interconnect between the picorv32 native bus (valid/ready) and N slave peripherals.
- Replaces the hand-written ready-OR and rdata-priority mux in the SoC top.
- Adds registered request and response stages, per-slave base/mask decode, a timeout watchdog, and a bus-error status register.
- Sits directly between the cpu instance and the ram, spirom, and generated peripheral instances.

Parameters:
- N_SLAVES, 4, number of slave ports (1..16)
- SLV_BASE, {N_SLAVES{32'h0}}, packed N_SLAVES×32 base addresses; slave i uses bits [32i+31:32i]
- SLV_MASK, {N_SLAVES{32'hFFFF_C000}}, packed N_SLAVES×32 masks; slave i hits when (m_addr & mask_i) == (base_i & mask_i)
- TIMEOUT, 255, cycles in ACTIVE without s_ready before abort (1..65535)
- STAT_ADDR, 32'h03FF_FF00, word address of the status register; STAT_ADDR+4 is the error-address register

Ports:
- clk  in  1  system clock
- resetn  in  1  reset
- m_valid  in  1  master request valid, held until m_ready
- m_ready  out  1  one-cycle response strobe
- m_addr  in  32  master address
- m_wdata  in  32  master write data
- m_wstrb  in  4  byte strobes; 0 means read
- m_rdata  out  32  read data, valid when m_ready=1
- s_valid  out  N_SLAVES  one-hot slave request
- s_ready  in  N_SLAVES  slave responses
- s_addr  out  32  registered address, broadcast to all slaves
- s_wdata  out  32  registered write data, broadcast to all slaves
- s_wstrb  out  4×N_SLAVES  per-slave strobes; nonselected slaves get 0
- s_rdata  in  32×N_SLAVES  packed slave read data
- irq_err  out  1  error interrupt (see Optional Feature)

Behaviour:
- Reset: resetn is synchronous, active-low. While low:
  - state←IDLE; s_valid=0, s_wstrb=0, m_ready=0, m_rdata=0, s_addr=0, s_wdata=0.
  - Timeout counter=0; status flags=0; err_addr=0; irq_err=0.
  - Reset asserted mid-transaction aborts it silently; the slave sees s_valid drop.
- States: IDLE, ACTIVE, RESP.
- IDLE, m_valid=1:
  - Latch m_addr, m_wdata, m_wstrb into s_addr/s_wdata/s_wstrb staging.
  - Decode priority: STAT_ADDR/STAT_ADDR+4 first, then lowest-index matching slave.
  - Slave hit → ACTIVE next cycle with s_valid[sel]=1 and s_wstrb[sel]=latched wstrb.
  - Status hit → RESP. Read data: status word, or err_addr. A write with any nonzero wstrb to STAT_ADDR clears flags and err_addr.
  - No hit → RESP with m_rdata=0. Set flag bit0 (decode error).
- ACTIVE:
  - Counter increments each cycle.
  - s_ready[sel]=1 → capture s_rdata[sel] into m_rdata; drop s_valid; go to RESP.
  - Counter==TIMEOUT with no s_ready → drop s_valid, m_rdata=0, set flag bit1 (timeout), record sel in status bits [11:8], go to RESP.
  - s_ready on the same cycle the counter reaches TIMEOUT counts as success.
  - s_ready from nonselected slaves is ignored.
- RESP: m_ready=1 for exactly one cycle, then IDLE. The master deasserts or re-requests on the following cycle, so there is no duplicate issue.
- Latency:
  - Slave answering with s_ready k cycles after s_valid rises (k≥0): m_ready appears k+3 cycles after m_valid is first sampled in IDLE. Zero-wait slave → 3 cycles.
  - Status register or decode error → 2 cycles.
- Status word: bit0 decode_err, bit1 timeout_err, [11:8] timed-out slave index, other bits 0. Flags are sticky.
- err_addr captures the faulting address only when both flags were 0 (first-error capture).
- m_rdata holds its last value outside RESP.

Optional Feature:
- BUS_ERR_IRQ_EN defined: irq_err is registered and equals (bit0|bit1). It rises the cycle after a flag sets and falls the cycle after the clearing write. The top wires it to irq[4].
- Undefined: irq_err is tied to 0, and no IRQ logic or flag-to-IRQ path is synthesised. The status registers remain.

Test Plan:
- Read slave 1 (base 32'h0005_0000, mask 32'hFFF0_0000, s_ready 2 cycles after s_valid, rdata 32'hCAFE_F00D) → s_valid=4'b0010 only; m_ready 5 cycles after request; m_rdata=32'hCAFE_F00D.
- Write 32'h1234_5678 with wstrb=4'b0011 to slave 0 at 32'h0000_0010 → s_wstrb[3:0]=4'b0011; all other slaves' strobes 0; s_wdata and s_addr match.
- Read 32'h0400_0000 (no match) → m_ready after 2 cycles with rdata 0; STAT_ADDR read returns 32'h1; STAT_ADDR+4 returns 32'h0400_0000.
- TIMEOUT=8, slave 2 never readies → s_valid[2] drops after 8 ACTIVE cycles; m_ready with rdata 0; status returns 32'h0000_0202. With BUS_ERR_IRQ_EN, irq_err=1.
- Write 4'b1111 to STAT_ADDR → flags clear; irq_err→0 the next cycle; second error then re-captures its address.
- resetn low for 1 cycle while in ACTIVE → next cycle s_valid=0, m_ready=0, state IDLE; a new request completes normally.

Source files
------------

// File: rtl/mmio_bus_fabric_if.sv
// mmio_bus_fabric_if: native valid/ready bus bundle between the cpu side, the fabric and N slaves
//   master modport: cpu/environment view (drives requests, slave responses)
//   slave  modport: fabric view (consumes requests, drives slave requests and the cpu response)
interface mmio_bus_fabric_if #(parameter int N_SLAVES = 4);
  logic                    m_valid;
  logic                    m_ready;
  logic [31:0]             m_addr;
  logic [31:0]             m_wdata;
  logic [3:0]              m_wstrb;
  logic [31:0]             m_rdata;
  logic [N_SLAVES-1:0]     s_valid;
  logic [N_SLAVES-1:0]     s_ready;
  logic [31:0]             s_addr;
  logic [31:0]             s_wdata;
  logic [4*N_SLAVES-1:0]   s_wstrb;
  logic [32*N_SLAVES-1:0]  s_rdata;
  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );
  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/mmio_bus_fabric.sv
// mmio_bus_fabric: registered valid/ready interconnect from the picorv32 bus to N decoded slaves
//   clk, resetn : clock, synchronous active-low reset
//   bus         : mmio_bus_fabric_if.slave (m_* from cpu, s_* to slaves)
//   irq_err     : bus-error interrupt, live only when BUS_ERR_IRQ_EN is defined
module mmio_bus_fabric #(
  parameter int                     N_SLAVES  = 4,
  parameter logic [32*N_SLAVES-1:0] SLV_BASE  = {N_SLAVES{32'h0}},
  parameter logic [32*N_SLAVES-1:0] SLV_MASK  = {N_SLAVES{32'hFFFF_C000}},
  parameter int                     TIMEOUT   = 255,
  parameter logic [31:0]            STAT_ADDR = 32'h03FF_FF00
) (
  input  logic                clk,
  input  logic                resetn,
  mmio_bus_fabric_if.slave    bus,
  output logic                irq_err
);
  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;
  state_t                  r_state;
  logic                    r_m_ready;
  logic [31:0]             r_m_rdata;
  logic [31:0]             r_s_addr;
  logic [31:0]             r_s_wdata;
  logic [N_SLAVES-1:0]     r_s_valid;
  logic [4*N_SLAVES-1:0]   r_s_wstrb;
  logic [3:0]              r_sel;
  logic [16:0]             r_cnt;
  logic                    r_dec_err;
  logic                    r_to_err;
  logic [3:0]              r_to_idx;
  logic [31:0]             r_err_addr;
  logic                    w_hit;
  logic [3:0]              w_sel;
  logic [N_SLAVES-1:0]     w_onehot;
  logic [4*N_SLAVES-1:0]   w_strb;
  logic [31:0]             w_rdata;
  logic                    w_rdy;
  logic                    w_stat0;
  logic                    w_stat1;
  logic [31:0]             w_status;
  logic [16:0]             w_cnt_nxt;
  // descending scan so the lowest matching index wins
  always_comb begin
    w_hit    = 1'b0;
    w_sel    = '0;
    w_onehot = '0;
    w_strb   = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--)
      if ((bus.m_addr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
        w_hit            = 1'b1;
        w_sel            = 4'(i);
        w_onehot         = '0;
        w_onehot[i]      = 1'b1;
        w_strb           = '0;
        w_strb[4*i +: 4] = bus.m_wstrb;
      end
  end
  // r_s_valid is one-hot on the selected slave, so it doubles as the response mux select
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++)
      if (r_s_valid[i]) w_rdata = bus.s_rdata[32*i +: 32];
  end
  assign w_rdy     = |(bus.s_ready & r_s_valid);
  assign w_stat0   = bus.m_addr[31:2] == STAT_ADDR[31:2];
  assign w_stat1   = bus.m_addr[31:2] == STAT_ADDR[31:2] + 30'd1;
  assign w_status  = {20'd0, r_to_idx, 6'd0, r_to_err, r_dec_err};
  assign w_cnt_nxt = r_cnt + 17'd1;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_m_ready  <= 1'b0;
      r_m_rdata  <= '0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_s_valid  <= '0;
      r_s_wstrb  <= '0;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_dec_err  <= 1'b0;
      r_to_err   <= 1'b0;
      r_to_idx   <= '0;
      r_err_addr <= '0;
    end else begin
      r_m_ready <= 1'b0;
      case (r_state)
        IDLE:
          // a request still held during the m_ready cycle is the one just answered
          if (bus.m_valid && !r_m_ready) begin
            r_s_addr  <= bus.m_addr;
            r_s_wdata <= bus.m_wdata;
            r_cnt     <= '0;
            if (w_stat0 || w_stat1) begin
              r_m_rdata <= w_stat0 ? w_status : r_err_addr;
              if (w_stat0 && |bus.m_wstrb) begin
                r_dec_err  <= 1'b0;
                r_to_err   <= 1'b0;
                r_to_idx   <= '0;
                r_err_addr <= '0;
              end
              r_state <= RESP;
            end else if (w_hit) begin
              r_s_valid <= w_onehot;
              r_s_wstrb <= w_strb;
              r_sel     <= w_sel;
              r_state   <= ACTIVE;
            end else begin
              r_m_rdata <= '0;
              r_dec_err <= 1'b1;
              if (!r_dec_err && !r_to_err) r_err_addr <= bus.m_addr;
              r_state <= RESP;
            end
          end
        ACTIVE: begin
          r_cnt <= w_cnt_nxt;
          // ready on the final counted cycle still completes normally
          if (w_rdy || w_cnt_nxt == 17'(TIMEOUT)) begin
            r_m_rdata <= w_rdy ? w_rdata : '0;
            r_s_valid <= '0;
            r_s_wstrb <= '0;
            r_state   <= RESP;
            if (!w_rdy) begin
              r_to_err <= 1'b1;
              r_to_idx <= r_sel;
              if (!r_dec_err && !r_to_err) r_err_addr <= r_s_addr;
            end
          end
        end
        RESP: begin
          r_m_ready <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.m_ready = r_m_ready;
  assign bus.m_rdata = r_m_rdata;
  assign bus.s_valid = r_s_valid;
  assign bus.s_addr  = r_s_addr;
  assign bus.s_wdata = r_s_wdata;
  assign bus.s_wstrb = r_s_wstrb;
`ifdef BUS_ERR_IRQ_EN
  logic r_irq;
  always_ff @(posedge clk)
    r_irq <= resetn ? (r_dec_err | r_to_err) : 1'b0;
  assign irq_err = r_irq;
`else
  assign irq_err = 1'b0;
`endif
endmodule
